// File: rtl/traffic_interval_timer.sv
// rtl/traffic_interval_timer.sv - interval timer and car-sensor conditioner for the traffic light FSM
//
// Purpose: turns the light FSM's ST pulse into sticky short (TS) and long (TL)
// interval-expired flags, and conditions the raw side-road sensor into C.
// Optional feature macro: CAR_DEBOUNCE_EN (adds a DEB_CYCLES debounce stage on C).
//
// Ports:
//   Clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   ST       in   start/restart timer request
//   tick_en  in   prescaler tick; the interval counter only advances when high
//   C_raw    in   raw asynchronous car sensor
//   TS       out  short interval expired (sticky until ST/reset)
//   TL       out  long interval expired (sticky until ST/reset)
//   C        out  synchronized (optionally debounced) car present
//   busy     out  timer running
//   count    out  current interval count
module traffic_interval_timer #(
  parameter int SHORT_CYCLES = 4,
  parameter int LONG_CYCLES  = 16,
  parameter int CNT_W        = 8,
  parameter int DEB_CYCLES   = 3
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             ST,
  input  logic             tick_en,
  input  logic             C_raw,
  output logic             TS,
  output logic             TL,
  output logic             C,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  // Elaboration-time parameter sanity checks.
  if (SHORT_CYCLES < 1 || SHORT_CYCLES >= LONG_CYCLES || LONG_CYCLES > (2**CNT_W) - 1) begin : g_bad_interval
    $error("traffic_interval_timer: need 1 <= SHORT_CYCLES < LONG_CYCLES <= 2**CNT_W-1");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("traffic_interval_timer: DEB_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ts_q, ts_d;
  logic             tl_q, tl_d;

  // ---------------------------------------------------------------------------
  // State register (interval counter and sticky flags travel with the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ts_q    <= 1'b0;
      tl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ts_q    <= ts_d;
      tl_q    <= tl_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ts_d    = ts_q;
    tl_d    = tl_q;
    if (ST) begin
      // Restart wins over ticking and over an expiry landing on this edge.
      state_d = S_RUN;
      count_d = '0;
      ts_d    = 1'b0;
      tl_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (tick_en) begin
            count_d = count_q + 1'b1;
            if (count_d == SHORT_C) ts_d = 1'b1;
            if (count_d == LONG_C) begin
              tl_d    = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_DONE;   // count saturates at LONG_CYCLES
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q == S_RUN);
    TS    = ts_q;
    TL    = tl_q;
    count = count_q;
  end

  // ---------------------------------------------------------------------------
  // Car sensor: two-flop synchronizer, always present
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = C_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef CAR_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             c_q, c_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive edges where the synchronized input disagrees with C;
  // the DEB_CYCLES-th such edge flips C. Any agreeing edge clears the run.
  always_comb begin
    c_d       = c_q;
    deb_cnt_d = '0;
    if (sync2_q != c_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        c_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q       <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      c_q       <= c_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign C = c_q;
`else
  assign C = sync2_q;
`endif

endmodule

// File: tb/tb_traffic_interval_timer.sv
// tb/tb_traffic_interval_timer.sv - self-checking bench for traffic_interval_timer
module tb_traffic_interval_timer;

  localparam int SHORT = 4;
  localparam int LONG  = 16;
  localparam int CW    = 8;
  localparam int DEB   = 3;

  logic          Clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ST = 1'b0;
  logic          tick_en = 1'b0;
  logic          C_raw = 1'b0;
  logic          TS, TL, C, busy;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: interval progress as "ticks since last ST".
  bit started = 1'b0;
  int ticks = 0;
  bit r0 = 1'b0, r1 = 1'b0;   // C_raw sampled at the last and previous edges
  bit c_deb = 1'b0;
  int deb_run = 0;

  traffic_interval_timer #(
    .SHORT_CYCLES(SHORT), .LONG_CYCLES(LONG), .CNT_W(CW), .DEB_CYCLES(DEB)
  ) dut (
    .Clk(Clk), .reset_n(reset_n), .ST(ST), .tick_en(tick_en), .C_raw(C_raw),
    .TS(TS), .TL(TL), .C(C), .busy(busy), .count(count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [CW+3:0] exp_vec();
    logic e_ts, e_tl, e_c, e_busy;
    logic [CW-1:0] e_cnt;
    e_ts   = started && ticks >= SHORT;
    e_tl   = started && ticks >= LONG;
    e_busy = started && ticks < LONG;
    e_cnt  = started ? CW'(ticks) : '0;
`ifdef CAR_DEBOUNCE_EN
    e_c = c_deb;
`else
    e_c = r1;
`endif
    return {e_ts, e_tl, e_c, e_busy, e_cnt};
  endfunction

  task automatic model_reset();
    started = 1'b0; ticks = 0; r0 = 1'b0; r1 = 1'b0; c_deb = 1'b0; deb_run = 0;
  endtask

  // Drive one clock edge and advance the model; outputs are settled on return.
  task automatic step(input logic st, input logic te, input logic raw);
    bit s2_old;
    @(negedge Clk);
    ST = st; tick_en = te; C_raw = raw;
    @(posedge Clk);
    s2_old = r1;
    if (st) begin
      started = 1'b1; ticks = 0;
    end else if (started && te && ticks < LONG) begin
      ticks++;
    end
    if (s2_old != c_deb) begin
      deb_run++;
      if (deb_run == DEB) begin c_deb = s2_old; deb_run = 0; end
    end else begin
      deb_run = 0;
    end
    r1 = r0; r0 = raw;
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({TS, TL, C, busy, count} !== '0) begin
      miscompares++; $display("FAIL reset_initial: got %h want 0", {TS, TL, C, busy, count});
    end
    @(negedge Clk); reset_n = 1'b1; model_reset();
    step(1, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1);
    vectors++;
    if (count !== 8'd7) begin
      miscompares++; $display("FAIL reset_pre_count: got %0d want 7", count);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({TS, TL, C, busy, count} !== '0) begin
      miscompares++; $display("FAIL reset_async: got %h want 0", {TS, TL, C, busy, count});
    end
    model_reset();
    @(negedge Clk); reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      vectors++;
      if (busy !== 1'b0 || count !== '0 || TS !== 1'b0 || TL !== 1'b0) begin
        miscompares++; $display("FAIL reset_stays_idle: got busy=%b count=%0d want busy=0 count=0", busy, count);
      end
    end
  endtask

  task automatic test_basic_interval();
    step(1, 1, 0);
    for (int e = 1; e <= LONG + 4; e++) begin
      step(0, 1, 0);
      vectors++;
      if ({TS, TL, C, busy, count} !== exp_vec()) begin
        miscompares++; $display("FAIL basic E%0d: got %h want %h", e, {TS, TL, C, busy, count}, exp_vec());
      end
      if (e == SHORT - 1 || e == SHORT || e == LONG) begin
        vectors++;
        if (TS !== (e >= SHORT) || TL !== (e == LONG) || busy !== (e != LONG)) begin
          miscompares++; $display("FAIL basic_edge E%0d: got TS=%b TL=%b busy=%b", e, TS, TL, busy);
        end
      end
    end
    vectors++;
    if (count !== CW'(LONG)) begin
      miscompares++; $display("FAIL basic_saturate: got %0d want %0d", count, LONG);
    end
  endtask

  task automatic test_restart();
    step(1, 1, 0);
    for (int e = 1; e < 10; e++) step(0, 1, 0);
    step(1, 1, 0);
    vectors++;
    if (TS !== 1'b0 || count !== '0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL restart_clear: got TS=%b count=%0d busy=%b want 0/0/1", TS, count, busy);
    end
    for (int e = 11; e <= 28; e++) begin
      step(0, 1, 0);
      vectors++;
      if ({TS, TL, C, busy, count} !== exp_vec()) begin
        miscompares++; $display("FAIL restart E%0d: got %h want %h", e, {TS, TL, C, busy, count}, exp_vec());
      end
      if (e == 14 || e == 26) begin
        vectors++;
        if ((e == 14 && TS !== 1'b1) || (e == 26 && TL !== 1'b1)) begin
          miscompares++; $display("FAIL restart_expiry E%0d: got TS=%b TL=%b", e, TS, TL);
        end
      end
    end
  endtask

  task automatic test_prescaler();
    logic [CW-1:0] prev;
    step(1, 1, 0);
    for (int e = 1; e <= 4 * LONG + 4; e++) begin
      prev = count;
      step(0, (e % 4) == 0, 0);
      vectors++;
      if ({TS, TL, C, busy, count} !== exp_vec() || ((e % 4) != 0 && count !== prev)) begin
        miscompares++; $display("FAIL prescaler E%0d: got %h want %h", e, {TS, TL, C, busy, count}, exp_vec());
      end
      if (e == 4 * SHORT || e == 4 * LONG) begin
        vectors++;
        if (TS !== 1'b1 || TL !== (e == 4 * LONG)) begin
          miscompares++; $display("FAIL prescaler_expiry E%0d: got TS=%b TL=%b", e, TS, TL);
        end
      end
    end
  endtask

  task automatic test_collision();
    step(1, 1, 0);
    for (int e = 1; e < LONG; e++) step(0, 1, 0);
    step(1, 1, 0);
    vectors++;
    if (TL !== 1'b0 || TS !== 1'b0 || count !== '0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL collision: got TS=%b TL=%b count=%0d busy=%b want 0/0/0/1", TS, TL, count, busy);
    end
  endtask

  task automatic test_sensor();
`ifdef CAR_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 2;
`endif
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0);
`ifdef CAR_DEBOUNCE_EN
    step(0, 0, 1); step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0);
      vectors++;
      if (C !== 1'b0) begin
        miscompares++; $display("FAIL sensor_glitch: got C=%b want 0", C);
      end
    end
`endif
    for (int e = 1; e <= LAT + 2; e++) begin
      step(0, 0, 1);
      vectors++;
      if (C !== (e >= LAT) || C !== exp_vec()[CW+1]) begin
        miscompares++; $display("FAIL sensor E%0d: got C=%b want %b", e, C, e >= LAT);
      end
    end
  endtask

  task automatic test_random();
    logic st, te, raw;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 24) == 0);
      te  = ($urandom_range(0, 3) != 0);
      raw = ($urandom_range(0, 3) == 0) ? ~C_raw : C_raw;
      step(st, te, raw);
      vectors++;
      if ({TS, TL, C, busy, count} !== exp_vec()) begin
        miscompares++; $display("FAIL random #%0d: got %h want %h", i, {TS, TL, C, busy, count}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_interval();
    test_restart();
    test_prescaler();
    test_collision();
    test_sensor();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
